jtframe_dump_trig: RTL and testbench

- Synthesizable frame counter and capture-window generator for the game-level simulation and test top.
- Produces the `frame_cnt` and VS-synchronous dump gating that the waveform dump control consumes.
- Counts falling edges of vertical sync once ROM download finishes.
- Opens a dump window when the counter reaches a programmed start frame and closes it after a programmed number of frames.
- Gives on/off pulses so any dumper, or an on-chip capture buffer, can start and stop cleanly on frame boundaries.

---
 rtl/jtframe_dump_trig.sv | 138 +++++++++++++
 tb/tb_jtframe_dump_trig.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dump_trig.sv
// Frame counter and capture-window generator.
// Counts VS falling edges after ROM download and opens a dump window that
// starts at a programmed frame and lasts a programmed number of frames.
// Every output is registered, so the effect of a VS fall seen in one cycle
// appears on the outputs in the following cycle.
module jtframe_dump_trig #(
    parameter int CNTW = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    input  logic            downloading,
    input  logic [CNTW-1:0] dump_start,
    input  logic [LENW-1:0] dump_len,
    output logic [CNTW-1:0] frame_cnt,
    output logic            vs_fall,
    output logic            dump_en,
    output logic            dump_on,
    output logic            dump_off,
    output logic            done
);

    typedef enum logic [1:0] {
        DLOAD  = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            vs_l;
    logic            ev;
    logic [LENW-1:0] win_cnt, win_nxt;
    logic [CNTW-1:0] cnt_nxt;
    logic            en_nxt, on_nxt, off_nxt, done_nxt;
    logic [LENW:0]   win_inc;
    logic            win_last;

    // Saturating increment for the frame counter: sticks at all-ones.
    function automatic logic [CNTW-1:0] sat_inc_cnt(input logic [CNTW-1:0] v);
        return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    // Saturating increment for the window counter (matters when dump_len=0).
    function automatic logic [LENW-1:0] sat_inc_win(input logic [LENW-1:0] v);
        return (&v) ? v : v + {{(LENW-1){1'b0}}, 1'b1};
    endfunction

    assign ev = vs_l & ~vs;

    // One bit wider so a saturated win_cnt never wraps into a false match.
    assign win_inc  = {1'b0, win_cnt} + {{LENW{1'b0}}, 1'b1};
    assign win_last = (dump_len != '0) && (win_inc == {1'b0, dump_len});

    // Next-state and next-output decode; downloading overrides every event.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = frame_cnt;
        win_nxt   = win_cnt;
        en_nxt    = dump_en;
        on_nxt    = 1'b0;
        off_nxt   = 1'b0;
        done_nxt  = done;
        if (downloading) begin
            state_nxt = DLOAD;
            cnt_nxt   = '0;
            win_nxt   = '0;
            done_nxt  = 1'b0;
            en_nxt    = 1'b0;
            off_nxt   = dump_en;
        end else begin
            case (state)
                DLOAD: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (ev) begin
                        cnt_nxt = sat_inc_cnt(frame_cnt);
                        // Equality on the pre-increment count: a start frame
                        // that is already behind us never opens the window.
                        if (frame_cnt == dump_start) begin
                            state_nxt = ACTIVE;
                            en_nxt    = 1'b1;
                            on_nxt    = 1'b1;
                            win_nxt   = '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (ev) begin
                        cnt_nxt = sat_inc_cnt(frame_cnt);
                        win_nxt = sat_inc_win(win_cnt);
                        if (win_last) begin
                            state_nxt = DONE;
                            en_nxt    = 1'b0;
                            off_nxt   = 1'b1;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ev) cnt_nxt = sat_inc_cnt(frame_cnt);
                end
                default: begin
                    state_nxt = WAIT;
                end
            endcase
        end
    end

    // State, counters and registered outputs; vs_l resets high to mask a
    // spurious edge right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT;
            vs_l      <= 1'b1;
            frame_cnt <= '0;
            win_cnt   <= '0;
            vs_fall   <= 1'b0;
            dump_en   <= 1'b0;
            dump_on   <= 1'b0;
            dump_off  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            vs_l      <= vs;
            frame_cnt <= cnt_nxt;
            win_cnt   <= win_nxt;
            vs_fall   <= ev;
            dump_en   <= en_nxt;
            dump_on   <= on_nxt;
            dump_off  <= off_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Bench for jtframe_dump_trig: a full-width instance and a CNTW=4/LENW=3
// instance share vs/downloading/rst and are both tracked by a frame-level
// reference model every cycle, with extra directed checks at key points.
module tb_jtframe_dump_trig;

    logic        clk = 1'b0;
    logic        rst, vs, downloading;
    logic [31:0] dump_start;
    logic [15:0] dump_len;
    logic [31:0] frame_cnt;
    logic        vs_fall, dump_en, dump_on, dump_off, done;
    logic [3:0]  dump_start_s;
    logic [2:0]  dump_len_s;
    logic [3:0]  frame_cnt_s;
    logic        vs_fall_s, dump_en_s, dump_on_s, dump_off_s, done_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jtframe_dump_trig #(.CNTW(32), .LENW(16)) dut (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .dump_start(dump_start), .dump_len(dump_len),
        .frame_cnt(frame_cnt), .vs_fall(vs_fall), .dump_en(dump_en),
        .dump_on(dump_on), .dump_off(dump_off), .done(done)
    );

    jtframe_dump_trig #(.CNTW(4), .LENW(3)) dut_s (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .dump_start(dump_start_s), .dump_len(dump_len_s),
        .frame_cnt(frame_cnt_s), .vs_fall(vs_fall_s), .dump_en(dump_en_s),
        .dump_on(dump_on_s), .dump_off(dump_off_s), .done(done_s)
    );

    // Reference model: index 0 = full-width build, 1 = small build.
    longint m_cnt [2];
    longint m_win [2];
    bit     m_en  [2];
    bit     m_on  [2];
    bit     m_off [2];
    bit     m_done[2];
    bit     m_dl  [2];
    bit     m_fall;
    bit     m_vsp;
    longint cmax [2] = '{64'd4294967295, 64'd15};
    longint wmax [2] = '{64'd65535, 64'd7};

    function automatic void model_update();
        longint st [2];
        longint ln [2];
        longint pre;
        bit ev;
        st[0] = dump_start;   st[1] = dump_start_s;
        ln[0] = dump_len;     ln[1] = dump_len_s;
        if (rst) begin
            m_vsp = 1'b1; m_fall = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_win[i] = 0; m_en[i] = 0; m_on[i] = 0;
                m_off[i] = 0; m_done[i] = 0; m_dl[i] = 0;
            end
        end else begin
            ev = m_vsp && !vs;
            m_fall = ev;
            m_vsp = vs;
            for (int i = 0; i < 2; i++) begin
                m_on[i] = 0; m_off[i] = 0;
                if (downloading) begin
                    m_off[i] = m_en[i]; m_en[i] = 0; m_cnt[i] = 0;
                    m_done[i] = 0; m_win[i] = 0; m_dl[i] = 1;
                end else if (m_dl[i]) begin
                    m_dl[i] = 0;
                end else if (ev) begin
                    pre = m_cnt[i];
                    if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                    if (m_en[i]) begin
                        if (ln[i] != 0 && m_win[i] + 1 == ln[i]) begin
                            m_en[i] = 0; m_off[i] = 1; m_done[i] = 1;
                        end
                        if (m_win[i] < wmax[i]) m_win[i] = m_win[i] + 1;
                    end else if (!m_done[i] && pre == st[i]) begin
                        m_en[i] = 1; m_on[i] = 1; m_win[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt",       {32'd0, frame_cnt},   m_cnt[0]);
        chk("vs_fall",   {63'd0, vs_fall},     {63'd0, m_fall});
        chk("dump_en",   {63'd0, dump_en},     {63'd0, m_en[0]});
        chk("dump_on",   {63'd0, dump_on},     {63'd0, m_on[0]});
        chk("dump_off",  {63'd0, dump_off},    {63'd0, m_off[0]});
        chk("done",      {63'd0, done},        {63'd0, m_done[0]});
        chk("cnt_s",     {60'd0, frame_cnt_s}, m_cnt[1]);
        chk("vs_fall_s", {63'd0, vs_fall_s},   {63'd0, m_fall});
        chk("dump_en_s", {63'd0, dump_en_s},   {63'd0, m_en[1]});
        chk("dump_on_s", {63'd0, dump_on_s},   {63'd0, m_on[1]});
        chk("dump_off_s",{63'd0, dump_off_s},  {63'd0, m_off[1]});
        chk("done_s",    {63'd0, done_s},      {63'd0, m_done[1]});
        chk("pulse_excl", {63'd0, dump_on & dump_off}, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // n frames: vs high for period-4 cycles then low for 4 cycles.
    task automatic frames(input int n, input int period);
        for (int f = 0; f < n; f++) begin
            vs = 1'b1;
            repeat (period - 4) tick();
            vs = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b1; downloading = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1; downloading = 1'b0;
        dump_start = 32'd3; dump_len = 16'd2;
        dump_start_s = 4'd3; dump_len_s = 3'd2;

        // Reset state
        do_reset();
        chk("rst_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("rst_en",  {63'd0, dump_en}, 64'd0);
        chk("rst_done",{63'd0, done}, 64'd0);
        chk("rst_fall",{63'd0, vs_fall}, 64'd0);

        // Window opens at pre-count 3, closes two frames later
        for (int f = 1; f <= 8; f++) begin
            vs = 1'b1;
            repeat (96) tick();
            vs = 1'b0;
            tick();
            chk("t1_cnt", {32'd0, frame_cnt}, 64'(f));
            chk("t1_on",  {63'd0, dump_on},  {63'd0, (f == 4)});
            chk("t1_off", {63'd0, dump_off}, {63'd0, (f == 6)});
            chk("t1_en",  {63'd0, dump_en},  {63'd0, (f == 4 || f == 5)});
            repeat (3) tick();
        end
        chk("t1_done", {63'd0, done}, 64'd1);

        // Start 0, endless window
        dump_start = 32'd0; dump_len = 16'd0;
        do_reset();
        frames(1, 20);
        chk("t2_en_first", {63'd0, dump_en}, 64'd1);
        frames(10, 20);
        chk("t2_en_last", {63'd0, dump_en}, 64'd1);
        chk("t2_done",    {63'd0, done}, 64'd0);

        // Download during the window, then reopen
        dump_start = 32'd2; dump_len = 16'd0;
        do_reset();
        frames(5, 20);
        chk("t3_pre_en", {63'd0, dump_en}, 64'd1);
        vs = 1'b1; downloading = 1'b1;
        tick();
        chk("t3_en",  {63'd0, dump_en}, 64'd0);
        chk("t3_off", {63'd0, dump_off}, 64'd1);
        chk("t3_cnt", {32'd0, frame_cnt}, 64'd0);
        repeat (5) tick();
        downloading = 1'b0;
        tick();
        frames(2, 20);
        chk("t3_closed", {63'd0, dump_en}, 64'd0);
        vs = 1'b1; repeat (16) tick();
        vs = 1'b0; tick();
        chk("t3_reopen", {63'd0, dump_on}, 64'd1);

        // VS fall coincident with download start
        dump_start = 32'd0;
        do_reset();
        repeat (3) tick();
        vs = 1'b0; downloading = 1'b1;
        tick();
        chk("t4_fall", {63'd0, vs_fall}, 64'd1);
        chk("t4_cnt",  {32'd0, frame_cnt}, 64'd0);
        chk("t4_on",   {63'd0, dump_on}, 64'd0);
        downloading = 1'b0; vs = 1'b1;
        repeat (3) tick();

        // Static vs: no edges, no counting
        dump_start = 32'd100;
        do_reset();
        frames(2, 20);
        repeat (30) tick();
        chk("t5_low_cnt",  {32'd0, frame_cnt}, 64'd2);
        chk("t5_low_fall", {63'd0, vs_fall}, 64'd0);
        vs = 1'b1;
        repeat (30) tick();
        chk("t5_hi_cnt",  {32'd0, frame_cnt}, 64'd2);
        chk("t5_hi_fall", {63'd0, vs_fall}, 64'd0);

        // Saturation on the small build; start frame already passed
        dump_start_s = 4'd10; dump_len_s = 3'd0;
        do_reset();
        frames(5, 12);
        dump_start_s = 4'd2;
        frames(20, 12);
        chk("t6_sat", {60'd0, frame_cnt_s}, 64'd15);
        chk("t6_en",  {63'd0, dump_en_s}, 64'd0);

        // Reset mid-window
        dump_start = 32'd1; dump_len = 16'd0;
        do_reset();
        frames(3, 20);
        chk("t7_open", {63'd0, dump_en}, 64'd1);
        rst = 1'b1;
        tick();
        chk("t7_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("t7_en",  {63'd0, dump_en}, 64'd0);
        chk("t7_off", {63'd0, dump_off}, 64'd0);
        chk("t7_on",  {63'd0, dump_on}, 64'd0);
        chk("t7_done",{63'd0, done}, 64'd0);
        rst = 1'b0;

        // Randomized run against the model
        dump_start = 32'd2; dump_len = 16'd2;
        dump_start_s = 4'd2; dump_len_s = 3'd2;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) downloading = ~downloading;
            if ($urandom_range(0, 7) == 0) vs = ~vs;
            if ($urandom_range(0, 99) == 0) begin
                dump_start   = 32'($urandom_range(0, 6));
                dump_len     = 16'($urandom_range(0, 3));
                dump_start_s = 4'($urandom_range(0, 6));
                dump_len_s   = 3'($urandom_range(0, 3));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
